// File: rtl/dbus_pma_gate.sv
// dbus_pma_gate: LSU data-bus front end. Every accepted load/store is checked
// for alignment and physical memory attributes. Legal transfers run on the
// AHB-Lite master port, one at a time. Faulting or deferred requests are
// answered locally without any bus activity.

package dbus_pma_gate_pkg;

   // One PMA region: inclusive byte range [base, last] plus its attributes.
   typedef struct packed {
      logic [31:0] base;
      logic [31:0] last;
      logic        r;
      logic        w;
      logic        x;
      logic        idem;
   } pma_cfg_t;

   localparam pma_cfg_t PMA_RAM = '{base: 32'h0000_0000, last: 32'h0000_FFFF,
                                    r: 1'b1, w: 1'b1, x: 1'b1, idem: 1'b1};
   localparam pma_cfg_t PMA_ROM = '{base: 32'h0001_0000, last: 32'h0001_FFFF,
                                    r: 1'b1, w: 1'b0, x: 1'b1, idem: 1'b1};
   localparam pma_cfg_t PMA_PER = '{base: 32'h1000_0000, last: 32'h1000_FFFF,
                                    r: 1'b1, w: 1'b1, x: 1'b0, idem: 1'b0};

   // Region 0 is RAM, region 1 is ROM, region 2 is the peripheral window.
   localparam pma_cfg_t [2:0] PMA_DEFAULT = {PMA_PER, PMA_ROM, PMA_RAM};

endpackage

// Physical memory attribute lookup. The lowest-numbered matching region wins;
// an address that matches no region is a violation.
module dbus_pma
   import dbus_pma_gate_pkg::*;
#(
   parameter int unsigned              PMA_ALIGN   = 10,
   parameter int unsigned              PMA_REGIONS = 3,
   parameter bit                       FETCH       = 1'b0,
   parameter pma_cfg_t [PMA_REGIONS-1:0] PMA_CFG   = PMA_DEFAULT
) (
   input  logic [31:0] addr,
   input  logic        write,
   output logic        violation,
   output logic        idempotent
);

   // Bits below PMA_ALIGN are masked off on both sides of the comparison.
   localparam logic [31:0] ALIGN_MASK = ~((32'd1 << PMA_ALIGN) - 32'd1);

   logic hit;
   logic allow;

   // Scan high to low so the lowest matching region is the one that sticks.
   always_comb begin
      hit        = 1'b0;
      allow      = 1'b0;
      idempotent = 1'b0;
      for (int i = int'(PMA_REGIONS) - 1; i >= 0; i--) begin
         if (((addr & ALIGN_MASK) >= (PMA_CFG[i].base & ALIGN_MASK)) &&
             ((addr & ALIGN_MASK) <= (PMA_CFG[i].last & ALIGN_MASK))) begin
            hit        = 1'b1;
            allow      = FETCH ? PMA_CFG[i].x : (write ? PMA_CFG[i].w : PMA_CFG[i].r);
            idempotent = PMA_CFG[i].idem;
         end
      end
      violation = !(hit && allow);
   end

endmodule

module dbus_pma_gate
   import dbus_pma_gate_pkg::*;
#(
   parameter int unsigned              PMA_ALIGN   = 10,
   parameter int unsigned              PMA_REGIONS = 3,
   parameter pma_cfg_t [PMA_REGIONS-1:0] PMA_CFG   = PMA_DEFAULT
) (
   input  logic        s_clk_i,
   input  logic        s_resetn_i,
   input  logic        s_req_valid_i,
   output logic        s_req_ready_o,
   input  logic [31:0] s_req_addr_i,
   input  logic        s_req_write_i,
   input  logic [1:0]  s_req_size_i,
   input  logic [31:0] s_req_wdata_i,
   input  logic        s_req_spec_i,
   output logic        s_rsp_valid_o,
   output logic [31:0] s_rsp_rdata_o,
   output logic [1:0]  s_rsp_code_o,
   output logic        s_rsp_defer_o,
   output logic [31:0] s_haddr_o,
   output logic        s_hwrite_o,
   output logic [2:0]  s_hsize_o,
   output logic [1:0]  s_htrans_o,
   output logic [31:0] s_hwdata_o,
   input  logic [31:0] s_hrdata_i,
   input  logic        s_hready_i,
   input  logic        s_hresp_i
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [1:0] CODE_OK    = 2'd0;
   localparam logic [1:0] CODE_PMA   = 2'd1;
   localparam logic [1:0] CODE_BUS   = 2'd2;
   localparam logic [1:0] CODE_ALIGN = 2'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_LOCAL} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, wdata_q;
   logic        write_q;
   logic [1:0]  size_q;
   logic        rsp_valid_q, rsp_defer_q;
   logic [1:0]  rsp_code_q;
   logic [31:0] rsp_rdata_q;

   logic        accept;
   logic        misaligned;
   logic        pma_violation;
   logic        pma_idem;
   logic        local_rsp;
   logic [1:0]  local_code;
   logic        local_defer;
   logic        bus_done;

   // The PMA looks at the live request so the decision is made in the accept cycle.
   dbus_pma #(
      .PMA_ALIGN   (PMA_ALIGN),
      .PMA_REGIONS (PMA_REGIONS),
      .FETCH       (1'b0),
      .PMA_CFG     (PMA_CFG)
   ) u_pma (
      .addr       (s_req_addr_i),
      .write      (s_req_write_i),
      .violation  (pma_violation),
      .idempotent (pma_idem)
   );

   // Ready only in IDLE, and not during the response pulse that closes a bus transfer.
   assign s_req_ready_o = (state_q == ST_IDLE) && !rsp_valid_q;
   assign accept        = s_req_valid_i && s_req_ready_o;
   assign bus_done      = (state_q == ST_DATA) && s_hready_i;

   // Classify the incoming request: misalignment beats PMA, PMA beats deferral.
   always_comb begin
      misaligned  = (s_req_size_i == 2'd3) ||
                    ((s_req_size_i == 2'd1) && s_req_addr_i[0]) ||
                    ((s_req_size_i == 2'd2) && (s_req_addr_i[1:0] != 2'b00));
      local_rsp   = 1'b1;
      local_code  = CODE_ALIGN;
      local_defer = 1'b0;
      if (misaligned) begin
         local_code = CODE_ALIGN;
      end else if (pma_violation) begin
         local_code = CODE_PMA;
      end else if (s_req_spec_i && !pma_idem) begin
         local_code  = CODE_ALIGN;
         local_defer = 1'b1;
      end else begin
         local_rsp = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) state_q <= ST_IDLE;
      else             state_q <= state_d;
   end

   // FSM next-state: local answers take one cycle, bus transfers wait on hready.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = local_rsp ? ST_LOCAL : ST_ADDR;
         ST_LOCAL: state_d = ST_IDLE;
         ST_ADDR:  if (s_hready_i) state_d = ST_DATA;
         ST_DATA:  if (s_hready_i) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Capture the request on accept; the bus outputs are driven from here.
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         addr_q  <= s_req_addr_i;
         write_q <= s_req_write_i;
         size_q  <= s_req_size_i;
         wdata_q <= s_req_wdata_i;
      end
   end

   // Registered one-cycle response; all fields return to zero outside the pulse.
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         rsp_valid_q <= 1'b0;
         rsp_code_q  <= CODE_OK;
         rsp_defer_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_code_q  <= CODE_OK;
         rsp_defer_q <= 1'b0;
         rsp_rdata_q <= '0;
         if (accept && local_rsp) begin
            rsp_valid_q <= 1'b1;
            rsp_code_q  <= local_code;
            rsp_defer_q <= local_defer;
         end else if (bus_done) begin
            rsp_valid_q <= 1'b1;
            rsp_code_q  <= s_hresp_i ? CODE_BUS : CODE_OK;
            rsp_rdata_q <= (!s_hresp_i && !write_q) ? s_hrdata_i : '0;
         end
      end
   end

   assign s_rsp_valid_o = rsp_valid_q;
   assign s_rsp_code_o  = rsp_code_q;
   assign s_rsp_defer_o = rsp_defer_q;
   assign s_rsp_rdata_o = rsp_rdata_q;

   assign s_htrans_o = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign s_haddr_o  = addr_q;
   assign s_hwrite_o = write_q;
   assign s_hsize_o  = {1'b0, size_q};
   assign s_hwdata_o = wdata_q;

endmodule

// File: tb/tb_dbus_pma_gate.sv
// Bench for dbus_pma_gate: directed scenarios plus random traffic, with an
// AHB slave model and a reference model of the gate's decisions.
module tb_dbus_pma_gate;

   logic        s_clk_i = 1'b0;
   logic        s_resetn_i = 1'b0;
   logic        s_req_valid_i = 1'b0;
   logic        s_req_ready_o;
   logic [31:0] s_req_addr_i = '0;
   logic        s_req_write_i = 1'b0;
   logic [1:0]  s_req_size_i = '0;
   logic [31:0] s_req_wdata_i = '0;
   logic        s_req_spec_i = 1'b0;
   logic        s_rsp_valid_o;
   logic [31:0] s_rsp_rdata_o;
   logic [1:0]  s_rsp_code_o;
   logic        s_rsp_defer_o;
   logic [31:0] s_haddr_o;
   logic        s_hwrite_o;
   logic [2:0]  s_hsize_o;
   logic [1:0]  s_htrans_o;
   logic [31:0] s_hwdata_o;
   logic [31:0] s_hrdata_i = '0;
   logic        s_hready_i = 1'b1;
   logic        s_hresp_i = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 s_clk_i = ~s_clk_i;

   dbus_pma_gate dut (
      .s_clk_i       (s_clk_i),
      .s_resetn_i    (s_resetn_i),
      .s_req_valid_i (s_req_valid_i),
      .s_req_ready_o (s_req_ready_o),
      .s_req_addr_i  (s_req_addr_i),
      .s_req_write_i (s_req_write_i),
      .s_req_size_i  (s_req_size_i),
      .s_req_wdata_i (s_req_wdata_i),
      .s_req_spec_i  (s_req_spec_i),
      .s_rsp_valid_o (s_rsp_valid_o),
      .s_rsp_rdata_o (s_rsp_rdata_o),
      .s_rsp_code_o  (s_rsp_code_o),
      .s_rsp_defer_o (s_rsp_defer_o),
      .s_haddr_o     (s_haddr_o),
      .s_hwrite_o    (s_hwrite_o),
      .s_hsize_o     (s_hsize_o),
      .s_htrans_o    (s_htrans_o),
      .s_hwdata_o    (s_hwdata_o),
      .s_hrdata_i    (s_hrdata_i),
      .s_hready_i    (s_hready_i),
      .s_hresp_i     (s_hresp_i)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Memory map as the LSU sees it: RAM, ROM, peripheral window.
   function automatic void ref_decide(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                                      input logic sp, output logic bus, output logic [1:0] code,
                                      output logic defer);
      logic [31:0] lo [3] = '{32'h0000_0000, 32'h0001_0000, 32'h1000_0000};
      logic [31:0] hi [3] = '{32'h0000_FFFF, 32'h0001_FFFF, 32'h1000_FFFF};
      bit rd_ok [3] = '{1, 1, 1};
      bit wr_ok [3] = '{1, 0, 1};
      bit idem  [3] = '{1, 1, 0};
      int hit = -1;
      bus = 0; code = 0; defer = 0;
      for (int i = 0; i < 3; i++)
         if (hit < 0 && a >= lo[i] && a <= hi[i]) hit = i;
      if (sz == 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0)) code = 3;
      else if (hit < 0 || !(wr ? wr_ok[hit] : rd_ok[hit])) code = 1;
      else if (sp && !idem[hit]) begin code = 3; defer = 1; end
      else bus = 1;
   endfunction

   // One request from accept to the cycle after its response, with the slave
   // inserting wa address wait states and wdw data wait states.
   task automatic run_txn(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                          input logic [31:0] wd, input logic sp, input int wa, input int wdw,
                          input logic err);
      logic bus, defer;
      logic [1:0] code;
      int rsp_k = -1, n_rsp = 0, nonseq = 0, first_ns = -1, ac = 0, dc = 0;
      bit in_data = 0;
      logic [1:0]  got_code = 0;
      logic        got_defer = 0;
      logic [31:0] got_rdata = 0, last_rdata = 0;
      int wdw_e = (err && wdw < 1) ? 1 : wdw;
      ref_decide(a, wr, sz, sp, bus, code, defer);
      @(negedge s_clk_i);
      chk("ready_idle", {31'b0, s_req_ready_o}, 32'd1);
      s_req_valid_i = 1; s_req_addr_i = a; s_req_write_i = wr; s_req_size_i = sz;
      s_req_wdata_i = wd; s_req_spec_i = sp; s_hready_i = 1; s_hresp_i = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge s_clk_i);
         if (s_rsp_valid_o) begin
            n_rsp++;
            if (rsp_k < 0) begin
               rsp_k = k; got_code = s_rsp_code_o; got_defer = s_rsp_defer_o;
               got_rdata = s_rsp_rdata_o;
            end
            chk("ready_in_rsp", {31'b0, s_req_ready_o}, 32'd0);
            s_req_valid_i = 0;
         end else if (rsp_k < 0) begin
            // junk that must be ignored while the gate is busy
            s_req_addr_i = $urandom; s_req_write_i = 1'($urandom);
            s_req_size_i = 2'($urandom); s_req_spec_i = 1'($urandom);
         end
         if (rsp_k >= 0 && k == rsp_k + 1) begin
            chk("ready_after", {31'b0, s_req_ready_o}, 32'd1);
            s_hready_i = 1; s_hresp_i = 0;
            break;
         end
         if (in_data) begin
            chk("hwdata", s_hwdata_o, wd);
            s_hready_i = (dc >= wdw_e);
            s_hresp_i  = err && (dc + 1 >= wdw_e);
            s_hrdata_i = $urandom;
            if (s_hready_i) begin last_rdata = s_hrdata_i; in_data = 0; end
            dc++;
         end else if (s_htrans_o == 2'b10) begin
            nonseq++;
            if (first_ns < 0) first_ns = k;
            chk("haddr", s_haddr_o, a);
            chk("hwrite", {31'b0, s_hwrite_o}, {31'b0, wr});
            chk("hsize", {29'b0, s_hsize_o}, {30'b0, sz});
            s_hready_i = (ac >= wa);
            s_hresp_i = 0;
            if (s_hready_i) begin in_data = 1; dc = 0; end
            ac++;
         end else begin
            s_hready_i = 1; s_hresp_i = 0;
         end
      end
      s_req_valid_i = 0; s_hready_i = 1; s_hresp_i = 0;
      chk("rsp_seen", {31'b0, rsp_k >= 0}, 32'd1);
      chk("rsp_count", n_rsp, 1);
      if (bus) begin
         chk("first_nonseq", first_ns, 1);
         chk("nonseq_cycles", nonseq, wa + 1);
         chk("rsp_latency", rsp_k, wa + wdw_e + 3);
         chk("code", {30'b0, got_code}, err ? 32'd2 : 32'd0);
         chk("defer", {31'b0, got_defer}, 32'd0);
         chk("rdata", got_rdata, (err || wr) ? 32'd0 : last_rdata);
      end else begin
         chk("no_nonseq", nonseq, 0);
         chk("rsp_latency", rsp_k, 1);
         chk("code", {30'b0, got_code}, {30'b0, code});
         chk("defer", {31'b0, got_defer}, {31'b0, defer});
         chk("rdata", got_rdata, 32'd0);
      end
   endtask

   // Load stalled in ADDR for three cycles, then reset hits during DATA.
   task automatic reset_mid_txn();
      @(negedge s_clk_i);
      s_req_valid_i = 1; s_req_addr_i = 32'h0000_0400; s_req_write_i = 0;
      s_req_size_i = 2; s_req_spec_i = 0; s_hready_i = 0; s_hresp_i = 0;
      @(negedge s_clk_i);
      s_req_valid_i = 0;
      for (int k = 0; k < 3; k++) begin
         chk("rst_addr_hold", s_haddr_o, 32'h0000_0400);
         chk("rst_nonseq_hold", {30'b0, s_htrans_o}, 32'd2);
         s_hready_i = (k == 2);
         @(negedge s_clk_i);
      end
      chk("rst_in_data", {30'b0, s_htrans_o}, 32'd0);
      s_hready_i = 0;
      #1 s_resetn_i = 0;
      #1;
      chk("rst_htrans", {30'b0, s_htrans_o}, 32'd0);
      chk("rst_ready", {31'b0, s_req_ready_o}, 32'd1);
      chk("rst_haddr", s_haddr_o, 32'd0);
      @(negedge s_clk_i);
      s_resetn_i = 1; s_hready_i = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge s_clk_i);
         chk("rst_no_rsp", {31'b0, s_rsp_valid_o}, 32'd0);
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      int          r;
      logic        e;
      #2;
      chk("reset_ready", {31'b0, s_req_ready_o}, 32'd1);
      chk("reset_rsp_valid", {31'b0, s_rsp_valid_o}, 32'd0);
      chk("reset_code", {30'b0, s_rsp_code_o}, 32'd0);
      chk("reset_rdata", s_rsp_rdata_o, 32'd0);
      chk("reset_htrans", {30'b0, s_htrans_o}, 32'd0);
      chk("reset_haddr", s_haddr_o, 32'd0);
      chk("reset_hsize", {29'b0, s_hsize_o}, 32'd0);
      chk("reset_hwdata", s_hwdata_o, 32'd0);
      @(negedge s_clk_i);
      s_resetn_i = 1;

      run_txn(32'h0000_0100, 0, 2, 32'h0, 0, 0, 0, 0);        // best-case load
      run_txn(32'h0001_0040, 1, 2, 32'hDEAD_BEEF, 0, 0, 0, 0); // store to ROM
      run_txn(32'h0000_0102, 0, 2, 32'h0, 0, 0, 0, 0);        // misaligned word
      run_txn(32'h1000_0010, 0, 2, 32'h0, 1, 0, 0, 0);        // speculative peripheral
      run_txn(32'h1000_0010, 0, 2, 32'h0, 0, 1, 1, 0);        // committed peripheral
      run_txn(32'h0000_0200, 0, 2, 32'h0, 0, 0, 1, 1);        // bus error
      run_txn(32'h0000_0300, 1, 1, 32'h1234_5678, 0, 2, 2, 0); // store with waits
      run_txn(32'h2000_0000, 0, 0, 32'h0, 0, 0, 0, 0);        // unmapped
      run_txn(32'h0000_0003, 0, 3, 32'h0, 0, 0, 0, 0);        // size 3
      reset_mid_txn();
      run_txn(32'h0000_0104, 0, 2, 32'h0, 0, 0, 0, 0);        // clean after reset

      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 3);
         case (r)
            0: a = 32'h0000_0000 | {16'b0, 16'($urandom)};
            1: a = 32'h0001_0000 | {16'b0, 16'($urandom)};
            2: a = 32'h1000_0000 | {16'b0, 16'($urandom)};
            default: a = $urandom;
         endcase
         sz = 2'($urandom_range(0, 3));
         if (sz != 3 && $urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz) - 32'd1);
         e = ($urandom_range(0, 4) == 0);
         run_txn(a, 1'($urandom), sz, $urandom, 1'($urandom), $urandom_range(0, 2),
                 $urandom_range(0, 2), e);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
